// File: rtl/pipe_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipe_control_unit_pkg
// Shared definitions for the pipeline control unit:
//   - RV32 major-opcode constants used by the decoder
//   - forwarding-select encodings driven on fwd_a / fwd_b
//   - ctrl_t, the control bundle carried down the ID/EX, EX/MEM, MEM/WB stages
// -----------------------------------------------------------------------------
package pipe_control_unit_pkg;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    localparam logic [1:0] FWD_REGFILE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM    = 2'b10;

    // ecall_cond is the x17==10 condition captured alongside an ECALL in ID.
    typedef struct packed {
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic write_enable;
        logic pc_to_reg;
        logic alu_op_msb;
        logic is_ecall;
        logic ecall_cond;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(9'b0);

endpackage

// File: rtl/pipe_control_unit_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Stall / flush / forwarding decisions for the 5-stage pipeline.
// Configuration macro: PIPE_FORWARDING_EN
//   defined   : forward from EX/MEM (priority) or MEM/WB; stall on load-use only
//   undefined : no forwarding; stall while ID/EX or EX/MEM will write a source
// Ports:
//   id_*_i     ID-stage source indices, their "used" flags and valid
//   ex_redirect_i, halt_i   EX redirect and sticky halt flag
//   idex_* / exmem_* / memwb_*  destination index and write/read flags per stage
//   ex_rs1_i, ex_rs2_i      EX-stage sources (already zero when unused)
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, fwd_a_o, fwd_b_o
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_control_unit_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              id_valid_i,
    input  logic              ex_redirect_i,
    input  logic              halt_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [ADDR_W-1:0] idex_rd_i,
    input  logic              idex_we_i,
    input  logic              idex_mem_read_i,
    input  logic [ADDR_W-1:0] exmem_rd_i,
    input  logic              exmem_we_i,
    input  logic [ADDR_W-1:0] memwb_rd_i,
    input  logic              memwb_we_i,
    input  logic [ADDR_W-1:0] ex_rs1_i,
    input  logic [ADDR_W-1:0] ex_rs2_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    logic stall_s;
    logic unused_hazard_s;

    // x0 is hard-wired, so it can never be the subject of a dependency.
    function automatic logic id_reads(input logic [ADDR_W-1:0] rd,
                                      input logic [ADDR_W-1:0] rs1,
                                      input logic [ADDR_W-1:0] rs2,
                                      input logic              use1,
                                      input logic              use2);
        return (rd != REG_ZERO) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

`ifdef PIPE_FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs,
                                           input logic [ADDR_W-1:0] em_rd,
                                           input logic              em_we,
                                           input logic [ADDR_W-1:0] mw_rd,
                                           input logic              mw_we);
        logic [1:0] sel;
        if (rs == REG_ZERO) begin
            sel = FWD_REGFILE;
        end else if (em_we && (em_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (mw_we && (mw_rd == rs)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REGFILE;
        end
        return sel;
    endfunction

    // Only a load in EX cannot be forwarded in time; everything else bypasses.
    always_comb begin
        stall_s = id_valid_i && idex_mem_read_i &&
                  id_reads(idex_rd_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i);
        fwd_a_o = fwd_sel(ex_rs1_i, exmem_rd_i, exmem_we_i, memwb_rd_i, memwb_we_i);
        fwd_b_o = fwd_sel(ex_rs2_i, exmem_rd_i, exmem_we_i, memwb_rd_i, memwb_we_i);
    end

    assign unused_hazard_s = idex_we_i;
`else
    // Without bypassing, wait until the producer reaches MEM/WB (write-through regfile).
    always_comb begin
        stall_s = id_valid_i &&
                  ((idex_we_i  && id_reads(idex_rd_i,  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i)) ||
                   (exmem_we_i && id_reads(exmem_rd_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i)));
        fwd_a_o = FWD_REGFILE;
        fwd_b_o = FWD_REGFILE;
    end

    assign unused_hazard_s = ^{idex_mem_read_i, memwb_rd_i, memwb_we_i, ex_rs1_i, ex_rs2_i};
`endif

    // Fetch/decode control: halt freezes the PC, a redirect overrides any stall.
    always_comb begin
        if (halt_i) begin
            pc_write_o = 1'b0;
        end else if (ex_redirect_i) begin
            pc_write_o = 1'b1;
        end else begin
            pc_write_o = !stall_s;
        end
        ifid_write_o  = ex_redirect_i || !stall_s;
        ifid_flush_o  = ex_redirect_i;
        idex_bubble_o = !id_valid_i || ex_redirect_i || stall_s;
    end

endmodule

// File: rtl/pipe_control_unit.sv
// -----------------------------------------------------------------------------
// pipe_control_unit
// Decodes the ID instruction into a control bundle, carries it through the
// ID/EX, EX/MEM and MEM/WB registers, and raises a sticky halt when a qualified
// ECALL reaches MEM/WB. Hazard and forwarding decisions live in hazard_detect.
// Configuration macro: PIPE_FORWARDING_EN (see hazard_detect).
// Ports:
//   clk, reset_n (async, active low)
//   id_inst, id_valid, id_ecall_cond, ex_redirect   inputs
//   pc_write, ifid_write, ifid_flush                  fetch/decode control
//   ex_alu_src, ex_alu_op, ex_rd                      EX stage
//   mem_read, mem_write                               MEM stage
//   wb_mem_to_reg, wb_write_enable, wb_pc_to_reg, wb_rd   WB stage
//   fwd_a, fwd_b                                      operand select
//   halt                                              sticky program end
// -----------------------------------------------------------------------------
module pipe_control_unit
    import pipe_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           id_inst,
    input  logic                  id_valid,
    input  logic                  id_ecall_cond,
    input  logic                  ex_redirect,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  ex_alu_src,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_write_enable,
    output logic                  wb_pc_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  halt
);

    logic [6:0]            opcode_s;
    ctrl_t                 id_ctrl_s;
    logic [REG_ADDR_W-1:0] id_rd_s, id_rs1_s, id_rs2_s;
    logic                  id_rs1_used_s, id_rs2_used_s;
    logic                  idex_bubble_s;
    logic                  unused_bits_s;

    ctrl_t                 idex_ctrl_q, idex_ctrl_d;
    ctrl_t                 exmem_ctrl_q, exmem_ctrl_d;
    ctrl_t                 memwb_ctrl_q, memwb_ctrl_d;
    logic [REG_ADDR_W-1:0] idex_rd_q, idex_rd_d, idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;
    logic [REG_ADDR_W-1:0] exmem_rd_q, exmem_rd_d, memwb_rd_q, memwb_rd_d;
    logic                  halt_q, halt_d;

    assign opcode_s = id_inst[6:0];
    assign id_rd_s  = id_inst[7  +: REG_ADDR_W];
    assign id_rs1_s = id_inst[15 +: REG_ADDR_W];
    assign id_rs2_s = id_inst[20 +: REG_ADDR_W];

    // Opcode decode into the control bundle and source-usage flags.
    always_comb begin
        id_ctrl_s              = CTRL_BUBBLE;
        id_ctrl_s.mem_read     = (opcode_s == OP_LOAD);
        id_ctrl_s.mem_to_reg   = (opcode_s == OP_LOAD);
        id_ctrl_s.mem_write    = (opcode_s == OP_STORE);
        id_ctrl_s.alu_src      = !((opcode_s == OP_ARITH) || (opcode_s == OP_BRANCH));
        id_ctrl_s.write_enable = !((opcode_s == OP_STORE) || (opcode_s == OP_BRANCH));
        id_ctrl_s.pc_to_reg    = (opcode_s == OP_JAL) || (opcode_s == OP_JALR);
        id_ctrl_s.alu_op_msb   = (opcode_s == OP_ARITH) || (opcode_s == OP_ARITH_IMM) ||
                                 (opcode_s == OP_BRANCH);
        id_ctrl_s.is_ecall     = (opcode_s == OP_SYSTEM);
        id_ctrl_s.ecall_cond   = (opcode_s == OP_SYSTEM) && id_ecall_cond;
        id_rs1_used_s          = !((opcode_s == OP_LUI) || (opcode_s == OP_AUIPC) ||
                                   (opcode_s == OP_JAL));
        id_rs2_used_s          = (opcode_s == OP_ARITH) || (opcode_s == OP_STORE) ||
                                 (opcode_s == OP_BRANCH);
    end

    hazard_detect #(
        .ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_valid_i      (id_valid),
        .ex_redirect_i   (ex_redirect),
        .halt_i          (halt_q),
        .id_rs1_i        (id_rs1_s),
        .id_rs2_i        (id_rs2_s),
        .id_rs1_used_i   (id_rs1_used_s),
        .id_rs2_used_i   (id_rs2_used_s),
        .idex_rd_i       (idex_rd_q),
        .idex_we_i       (idex_ctrl_q.write_enable),
        .idex_mem_read_i (idex_ctrl_q.mem_read),
        .exmem_rd_i      (exmem_rd_q),
        .exmem_we_i      (exmem_ctrl_q.write_enable),
        .memwb_rd_i      (memwb_rd_q),
        .memwb_we_i      (memwb_ctrl_q.write_enable),
        .ex_rs1_i        (idex_rs1_q),
        .ex_rs2_i        (idex_rs2_q),
        .pc_write_o      (pc_write),
        .ifid_write_o    (ifid_write),
        .ifid_flush_o    (ifid_flush),
        .idex_bubble_o   (idex_bubble_s),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b)
    );

    // Stage advance; unused sources are zeroed so they can never forward.
    always_comb begin
        if (idex_bubble_s) begin
            idex_ctrl_d = CTRL_BUBBLE;
            idex_rd_d   = '0;
            idex_rs1_d  = '0;
            idex_rs2_d  = '0;
        end else begin
            idex_ctrl_d = id_ctrl_s;
            idex_rd_d   = id_rd_s;
            idex_rs1_d  = id_rs1_used_s ? id_rs1_s : '0;
            idex_rs2_d  = id_rs2_used_s ? id_rs2_s : '0;
        end
        exmem_ctrl_d = idex_ctrl_q;
        exmem_rd_d   = idex_rd_q;
        memwb_ctrl_d = exmem_ctrl_q;
        memwb_rd_d   = exmem_rd_q;
        // Set on the edge that moves the qualified ECALL into MEM/WB.
        halt_d       = halt_q || (exmem_ctrl_q.is_ecall && exmem_ctrl_q.ecall_cond);
    end

    // Pipeline registers and sticky halt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_ctrl_q  <= CTRL_BUBBLE;
            idex_rd_q    <= '0;
            idex_rs1_q   <= '0;
            idex_rs2_q   <= '0;
            exmem_ctrl_q <= CTRL_BUBBLE;
            exmem_rd_q   <= '0;
            memwb_ctrl_q <= CTRL_BUBBLE;
            memwb_rd_q   <= '0;
            halt_q       <= 1'b0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rd_q    <= idex_rd_d;
            idex_rs1_q   <= idex_rs1_d;
            idex_rs2_q   <= idex_rs2_d;
            exmem_ctrl_q <= exmem_ctrl_d;
            exmem_rd_q   <= exmem_rd_d;
            memwb_ctrl_q <= memwb_ctrl_d;
            memwb_rd_q   <= memwb_rd_d;
            halt_q       <= halt_d;
        end
    end

    // Only the MSB of the ALU-op field is ever set.
    always_comb begin
        ex_alu_op               = '0;
        ex_alu_op[ALU_OP_W-1]   = idex_ctrl_q.alu_op_msb;
    end

    assign ex_alu_src      = idex_ctrl_q.alu_src;
    assign ex_rd           = idex_rd_q;
    assign mem_read        = exmem_ctrl_q.mem_read;
    assign mem_write       = exmem_ctrl_q.mem_write;
    assign wb_mem_to_reg   = memwb_ctrl_q.mem_to_reg;
    assign wb_write_enable = memwb_ctrl_q.write_enable;
    assign wb_pc_to_reg    = memwb_ctrl_q.pc_to_reg;
    assign wb_rd           = memwb_rd_q;
    assign halt            = halt_q;

    assign unused_bits_s = ^{id_inst[31:25], id_inst[14:12],
                             memwb_ctrl_q.mem_read, memwb_ctrl_q.mem_write,
                             memwb_ctrl_q.alu_src, memwb_ctrl_q.alu_op_msb,
                             memwb_ctrl_q.is_ecall, memwb_ctrl_q.ecall_cond};

endmodule
